// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass, kernel alias and clear sequencer
//
// Purpose:
//   NUM_RD synchronous read ports and NUM_WR write ports over NUM_REGS x DATA_W
//   registers. Same-cycle writes bypass to reads. In kernel mode, index
//   ALIAS_REG can be redirected to a shadow register. After reset the array is
//   zeroed one entry per enabled cycle, so the array itself needs no reset.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   clk_en           cycle enable; all state advances only when 1 (reset excepted)
//   kmode            kernel mode (enables aliasing)
//   ren/raddr/rd_no_alias/rdata   read ports, packed per port, 1-cycle latency
//   wen/waddr/wdata/wr_no_alias   write ports, packed per port, higher index wins
//   ready            clear sequence finished
//   wr_conflict      registered pulse: several write ports hit one target
//   ret_val          regs[RET_REG], 0 until ready
module regfile_mp #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int ALIAS_EN  = 1,
  parameter int ALIAS_REG = 31,
  parameter int RET_REG   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     kmode,
  input  logic [NUM_RD-1:0]        ren,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic [NUM_RD-1:0]        rd_no_alias,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_WR-1:0]        wr_no_alias,
  output logic                     ready,
  output logic                     wr_conflict,
  output logic [DATA_W-1:0]        ret_val
);

  localparam logic [ADDR_W-1:0] ALIAS_A = ADDR_W'(ALIAS_REG);
  localparam logic [ADDR_W-1:0] RET_A   = ADDR_W'(RET_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] shadow;

  // Per write port: address, shadow redirect, and "really writes something".
  logic [ADDR_W-1:0] w_a   [NUM_WR];
  logic [NUM_WR-1:0] w_shd;
  logic [NUM_WR-1:0] w_act;
  logic              conflict;

  // Per read port: address, shadow redirect, next registered value.
  logic [ADDR_W-1:0] r_a    [NUM_RD];
  logic [NUM_RD-1:0] r_shd;
  logic [DATA_W-1:0] rd_nxt [NUM_RD];

  assign ready   = (state == RUN);
  assign ret_val = ready ? regs[RET_A] : '0;

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == LAST_A) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      state <= CLEAR;
    else if (clk_en) state <= state_nxt;
  end

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      w_a[j]   = waddr[j*ADDR_W +: ADDR_W];
      w_shd[j] = (ALIAS_EN != 0) && kmode && !wr_no_alias[j] && (w_a[j] == ALIAS_A);
      // Index 0 is not a target at all, so it neither writes nor conflicts.
      w_act[j] = wen[j] && (w_a[j] != '0);
    end
    conflict = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        // The shadow and regs[ALIAS_REG] share an index but are different targets.
        if (w_act[j] && w_act[k] && (w_a[j] == w_a[k]) && (w_shd[j] == w_shd[k]))
          conflict = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      r_a[i]    = raddr[i*ADDR_W +: ADDR_W];
      r_shd[i]  = (ALIAS_EN != 0) && kmode && !rd_no_alias[i] && (r_a[i] == ALIAS_A);
      rd_nxt[i] = r_shd[i] ? shadow : regs[r_a[i]];
      // Ascending scan so the highest-index matching write port wins the bypass.
      for (int j = 0; j < NUM_WR; j++) begin
        if (w_act[j] && (w_a[j] == r_a[i]) && (w_shd[j] == r_shd[i]))
          rd_nxt[i] = wdata[j*DATA_W +: DATA_W];
      end
      if (r_a[i] == '0) rd_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_idx     <= '0;
      shadow      <= '0;
      rdata       <= '0;
      wr_conflict <= 1'b0;
    end else if (clk_en) begin
      if (state == CLEAR) begin
        clr_idx <= clr_idx + ADDR_W'(1);
      end else begin
        wr_conflict <= conflict;
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_act[j] && w_shd[j]) shadow <= wdata[j*DATA_W +: DATA_W];
        end
        for (int i = 0; i < NUM_RD; i++) begin
          if (ren[i]) rdata[i*DATA_W +: DATA_W] <= rd_nxt[i];
        end
      end
    end
  end

  // Array kept free of reset so it can map onto RAM; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n && clk_en) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_act[j] && !w_shd[j]) regs[w_a[j]] <= wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (default and swept parameters)
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_rst_n, a_clk_en, a_kmode;
  logic [1:0]  a_ren, a_rd_no_alias, a_wen, a_wr_no_alias;
  logic [9:0]  a_raddr, a_waddr;
  logic [63:0] a_rdata, a_wdata;
  logic        a_ready, a_wr_conflict;
  logic [31:0] a_ret_val;

  regfile_mp dut_a (
    .clk(clk), .rst_n(a_rst_n), .clk_en(a_clk_en), .kmode(a_kmode),
    .ren(a_ren), .raddr(a_raddr), .rd_no_alias(a_rd_no_alias), .rdata(a_rdata),
    .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata), .wr_no_alias(a_wr_no_alias),
    .ready(a_ready), .wr_conflict(a_wr_conflict), .ret_val(a_ret_val)
  );

  // Instance B: swept parameters
  logic         b_rst_n, b_clk_en, b_kmode;
  logic [3:0]   b_ren, b_rd_no_alias;
  logic [15:0]  b_raddr;
  logic [255:0] b_rdata;
  logic [2:0]   b_wen, b_wr_no_alias;
  logic [11:0]  b_waddr;
  logic [191:0] b_wdata;
  logic         b_ready, b_wr_conflict;
  logic [63:0]  b_ret_val;

  regfile_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4), .NUM_WR(3),
               .ALIAS_EN(0), .ALIAS_REG(15), .RET_REG(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .clk_en(b_clk_en), .kmode(b_kmode),
    .ren(b_ren), .raddr(b_raddr), .rd_no_alias(b_rd_no_alias), .rdata(b_rdata),
    .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .wr_no_alias(b_wr_no_alias),
    .ready(b_ready), .wr_conflict(b_wr_conflict), .ret_val(b_ret_val)
  );

  typedef struct {
    bit          inst_b;
    int          port;
    logic [63:0] val;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt;

  logic [63:0] mref    [16];
  logic [63:0] last_rd [4];
  logic [3:0]  ra, wa [3];
  logic [63:0] wd [3];
  logic [63:0] e_val;
  logic        e_conf;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.inst_b) got = b_rdata[e.port*64 +: 64];
      else          got = {32'h0, a_rdata[e.port*32 +: 32]};
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic push(input bit ib, input int p, input logic [63:0] v, input string tag);
    exp_t e;
    e.inst_b = ib; e.port = p; e.val = v; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic a_idle();
    a_wen = '0; a_ren = '0; a_rd_no_alias = '0; a_wr_no_alias = '0;
  endtask

  task automatic a_wr(input int p, input int addr, input logic [31:0] d, input bit na);
    a_wen[p] = 1'b1;
    a_waddr[p*5 +: 5] = 5'(addr);
    a_wdata[p*32 +: 32] = d;
    a_wr_no_alias[p] = na;
  endtask

  task automatic a_rd(input int p, input int addr, input bit na, input logic [31:0] exp, input string tag);
    a_ren[p] = 1'b1;
    a_raddr[p*5 +: 5] = 5'(addr);
    a_rd_no_alias[p] = na;
    push(1'b0, p, {32'h0, exp}, tag);
  endtask

  task automatic a_clear_count(input string tag);
    en_cnt = 0;
    for (int c = 0; c < 200 && !a_ready; c++) begin
      a_clk_en = (c % 2 == 0);
      @(posedge clk); #1;
      if (a_clk_en) en_cnt++;
      if (!a_ready) begin
        chk({tag, "_rdata"}, a_rdata, 0);
        chk({tag, "_ret_val"}, a_ret_val, 0);
        chk({tag, "_conflict"}, a_wr_conflict, 0);
      end
    end
    a_clk_en = 1'b1;
    chk({tag, "_ready"}, a_ready, 1);
    chk({tag, "_len"}, en_cnt, 32);
  endtask

  initial begin
    a_rst_n = 0; a_clk_en = 1; a_kmode = 0; a_idle();
    a_raddr = '0; a_waddr = '0; a_wdata = '0;
    b_rst_n = 0; b_clk_en = 0; b_kmode = 0;
    b_ren = '0; b_raddr = '0; b_rd_no_alias = '0;
    b_wen = '0; b_waddr = '0; b_wdata = '0; b_wr_no_alias = '0;
    tick(); tick();

    chk("rst_ready", a_ready, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_conflict", a_wr_conflict, 0);
    chk("rst_ret_val", a_ret_val, 0);

    // 1: clear with clk_en toggling; writes during clear are ignored
    a_rst_n = 1;
    a_ren = 2'b11; a_raddr = {5'd31, 5'd3};
    a_wr(0, 3, 32'h1111_1111, 0); a_wr(1, 3, 32'h2222_2222, 0);
    a_clear_count("clr1");
    a_idle();
    a_rd(0, 3, 0, 32'h0, "rd_r3_zero");
    a_rd(1, 31, 0, 32'h0, "rd_r31_zero");
    tick();
    chk("ret_val_zero", a_ret_val, 0);

    // 2: write-to-read bypass
    a_idle();
    a_wr(0, 5, 32'hDEAD_BEEF, 0);
    a_rd(1, 5, 0, 32'hDEAD_BEEF, "bypass_r5");
    tick(); a_idle();
    a_rd(0, 5, 0, 32'hDEAD_BEEF, "rd_r5");
    tick(); a_idle();

    // 3: priority, conflict pulse, r0
    a_wr(0, 7, 32'h11, 0); a_wr(1, 7, 32'h22, 0);
    tick();
    chk("conflict_r7", a_wr_conflict, 1);
    a_idle();
    a_rd(0, 7, 0, 32'h22, "r7_prio");
    a_wr(0, 0, 32'h55, 0);
    a_rd(1, 0, 0, 32'h0, "r0_bypass");
    tick();
    chk("conflict_drop", a_wr_conflict, 0);
    a_idle();
    a_rd(0, 0, 0, 32'h0, "r0_read");
    a_wr(0, 8, 32'h88, 0); a_wr(1, 9, 32'h99, 0);
    tick();
    chk("no_conflict_diff", a_wr_conflict, 0);
    a_idle();
    a_wr(1, 1, 32'h77, 0);
    tick();
    chk("ret_val_r1", a_ret_val, 32'h77);
    a_idle();

    // 4: kernel alias
    a_wr(0, 31, 32'h1234, 0);
    tick(); a_idle();
    a_kmode = 1;
    a_wr(0, 31, 32'h1234, 1); a_wr(1, 31, 32'hAAAA, 0);
    tick();
    chk("no_conflict_alias", a_wr_conflict, 0);
    a_idle();
    a_rd(0, 31, 0, 32'hAAAA, "shadow_rd");
    a_rd(1, 31, 1, 32'h1234, "noalias_rd");
    tick(); a_idle();
    a_wr(0, 31, 32'hBBBB, 0);
    a_rd(0, 31, 1, 32'h1234, "noalias_no_bypass");
    a_rd(1, 31, 0, 32'hBBBB, "alias_bypass");
    tick(); a_idle();
    a_kmode = 0;
    a_rd(0, 31, 0, 32'h1234, "user_rd");
    tick(); a_idle();
    chk("ret_val_hold", a_ret_val, 32'h77);

    // clk_en=0 freezes everything
    a_clk_en = 0;
    a_wr(0, 5, 32'h0, 0);
    a_ren = 2'b11; a_raddr = {5'd7, 5'd7};
    tick();
    chk("gated_hold", a_rdata, {32'hBBBB, 32'h1234});
    a_clk_en = 1; a_idle();
    a_rd(0, 5, 0, 32'hDEAD_BEEF, "gated_no_write");
    tick(); a_idle();

    // 5: reset mid-clear restarts the sequence
    a_rst_n = 0; tick(); a_rst_n = 1;
    for (int c = 0; c < 10; c++) tick();
    chk("mid_clear_ready", a_ready, 0);
    a_rst_n = 0; tick();
    chk("rerst_ready", a_ready, 0);
    chk("rerst_rdata", a_rdata, 0);
    a_rst_n = 1;
    a_clear_count("clr2");
    a_idle();
    a_kmode = 1;
    a_rd(0, 31, 0, 32'h0, "shadow_cleared");
    a_rd(1, 5, 0, 32'h0, "r5_cleared");
    tick(); a_idle(); a_kmode = 0;

    // 6: swept parameters with reference model
    b_clk_en = 1; tick(); b_rst_n = 1;
    en_cnt = 0;
    for (int c = 0; c < 100 && !b_ready; c++) begin
      @(posedge clk); #1;
      en_cnt++;
    end
    chk("b_clr_len", en_cnt, 16);
    chk("b_ret_val_clr", b_ret_val, 0);
    for (int r = 0; r < 16; r++) mref[r] = '0;
    for (int i = 0; i < 4; i++) last_rd[i] = '0;

    for (int cyc = 0; cyc < 80; cyc++) begin
      b_kmode = 1'($urandom);
      for (int j = 0; j < 3; j++) begin
        case ($urandom_range(0, 5))
          0: wa[j] = 4'd0;
          1: wa[j] = 4'd1;
          2: wa[j] = 4'd2;
          3: wa[j] = 4'd15;
          default: wa[j] = 4'($urandom);
        endcase
        wd[j] = {$urandom, $urandom};
        b_wen[j] = 1'($urandom);
        b_wr_no_alias[j] = 1'($urandom);
        b_waddr[j*4 +: 4] = wa[j];
        b_wdata[j*64 +: 64] = wd[j];
      end
      e_conf = 0;
      for (int j = 0; j < 3; j++)
        for (int k = j + 1; k < 3; k++)
          if (b_wen[j] && b_wen[k] && wa[j] != 0 && wa[j] == wa[k]) e_conf = 1;
      for (int i = 0; i < 4; i++) begin
        ra = (i == 3) ? 4'd15 : 4'($urandom_range(0, 3));
        b_ren[i] = 1'($urandom);
        b_rd_no_alias[i] = 1'($urandom);
        b_raddr[i*4 +: 4] = ra;
        if (b_ren[i]) begin
          e_val = mref[ra];
          for (int j = 0; j < 3; j++)
            if (b_wen[j] && wa[j] == ra) e_val = wd[j];
          if (ra == 0) e_val = '0;
          last_rd[i] = e_val;
        end
        push(1'b1, i, last_rd[i], $sformatf("b_rd%0d_c%0d", i, cyc));
      end
      for (int j = 0; j < 3; j++)
        if (b_wen[j] && wa[j] != 0) mref[wa[j]] = wd[j];
      tick();
      chk($sformatf("b_conflict_c%0d", cyc), b_wr_conflict, e_conf);
      chk($sformatf("b_ret_val_c%0d", cyc), b_ret_val, mref[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
